retospect_bs_loader: RTL

//  Host-side driver for the neurochip configuration shift chain (clockbox + CNB cells).

---
 rtl/retospect_bs_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/retospect_bs_loader.sv
// rtl/retospect_bs_loader.sv - serialises config bytes onto the neurochip shift chain,
// captures the bits returning from the far end as readback bytes, then pulses nn_reset.
module retospect_bs_loader #(
    parameter int CHAIN_LEN = 523,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       config_en,
    output logic       bs_out,
    input  logic       bs_ret,
    output logic       nn_reset,
    output logic       busy,
    output logic       done,
    output logic       err_underrun
);
    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int ACC_W  = $clog2(NBYTES + 1);
    localparam logic [ACC_W-1:0] NBYTES_A = ACC_W'(NBYTES);
    localparam logic [1:0]       PRIME_N  = (NBYTES < 2) ? 2'(NBYTES) : 2'd2;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_SHIFT, S_ARM, S_DONE, S_ERROR} state_t;

    state_t           state_q, state_d;
    logic [7:0]       fifo_q [2];
    logic [7:0]       fifo_d [2];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             starve_q, starve_d;
    logic             err_q, err_d;
    logic [7:0]       rb_sh_q, rb_sh_d, rb_data_q, rb_data_d;
    logic             rb_valid_q, rb_valid_d;

    logic       start_acc, push, pop, prime_ok, at_last, byte_end;
    logic [7:0] rb_byte;

    assign start_acc = start && (state_q == S_IDLE || state_q == S_ERROR);
    assign push      = in_valid && in_ready;
    assign prime_ok  = fifo_cnt_q >= PRIME_N;
    assign at_last   = bit_cnt_q == LAST_BIT;
    assign byte_end  = bit_cnt_q[2:0] == 3'd7;
    // A fresh byte starts from zero so the final partial byte comes out zero-padded.
    assign rb_byte   = ((bit_cnt_q[2:0] == 3'd0) ? 8'h00 : rb_sh_q)
                       | (8'({7'b0, bs_ret}) << bit_cnt_q[2:0]);

    assign rb_data      = rb_data_q;
    assign rb_valid     = rb_valid_q;
    assign err_underrun = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PRIME;
            S_PRIME: if (prime_ok) state_d = S_SHIFT;
            S_SHIFT: begin
                if (starve_q)     state_d = S_ERROR;
                else if (at_last) state_d = S_ARM;
            end
            S_ARM:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERROR: if (start) state_d = S_PRIME;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != S_IDLE && state_q != S_ERROR;
        config_en = state_q == S_SHIFT && !starve_q;
        bs_out    = config_en && shreg_q[0];
        nn_reset  = state_q == S_ARM;
        done      = state_q == S_DONE;
        in_ready  = busy && fifo_cnt_q != 2'd2 && acc_q != NBYTES_A;
        pop       = (state_q == S_PRIME && prime_ok)
                    || (config_en && byte_end && !at_last && fifo_cnt_q != 2'd0);
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        acc_d      = acc_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        err_d      = err_q;
        rb_sh_d    = rb_sh_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        // The chain cannot pause, so a missing byte at a boundary aborts the frame next cycle.
        starve_d   = config_en && byte_end && !at_last && fifo_cnt_q == 2'd0;
        if (start_acc) begin
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
            acc_d      = '0;
            bit_cnt_d  = '0;
            err_d      = 1'b0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = in_data;
                wr_ptr_d         = ~wr_ptr_q;
                acc_d            = acc_q + 1'b1;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
            if (pop)            shreg_d = fifo_q[rd_ptr_q];
            else if (config_en) shreg_d = {1'b0, shreg_q[7:1]};
            if (config_en) bit_cnt_d = bit_cnt_q + 1'b1;
            if (state_q == S_SHIFT && starve_q) err_d = 1'b1;
        end
        if (config_en) begin
            rb_sh_d = rb_byte;
            if (byte_end || at_last) begin
                rb_data_d  = rb_byte;
                rb_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q[0]  <= 8'h00;
            fifo_q[1]  <= 8'h00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            acc_q      <= '0;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= '0;
            starve_q   <= 1'b0;
            err_q      <= 1'b0;
            rb_sh_q    <= 8'h00;
            rb_data_q  <= 8'h00;
            rb_valid_q <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            acc_q      <= acc_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
            rb_sh_q    <= rb_sh_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end
endmodule
